// File: rtl/image_resize_avg_stream.sv
// Streaming block-average image downscaler: fetches each BLK_W x BLK_H block pixel by pixel,
// divides the sum by N with a restoring divider. Define IMAGE_RESIZE_ROUND_EN for round-half-up.
module image_resize_avg_stream #(
  parameter int unsigned SRC_W     = 640,
  parameter int unsigned SRC_H     = 480,
  parameter int unsigned BLK_W     = 20,
  parameter int unsigned BLK_H     = 15,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned BASE_ADDR = 0,
  localparam int unsigned OUT_W    = SRC_W / BLK_W,
  localparam int unsigned OUT_H    = SRC_H / BLK_H,
  localparam int unsigned N        = BLK_W * BLK_H,
  localparam int unsigned SUM_W    = PIX_W + $clog2(N) + 1,
  localparam int unsigned OA_W     = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              out_we,
  output logic [OA_W-1:0]   out_addr,
  output logic [PIX_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int unsigned PY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int unsigned BX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned BY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned DC_W = $clog2(SUM_W);

`ifdef IMAGE_RESIZE_ROUND_EN
  localparam logic [SUM_W-1:0] RND = SUM_W'(N / 2);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDiv, StWrite, StDone} state_e;

  state_e            state_q;
  logic [PX_W-1:0]   px_q;
  logic [PY_W-1:0]   py_q;
  logic [BX_W-1:0]   bx_q;
  logic [BY_W-1:0]   by_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  dvd_q;
  logic [SUM_W-1:0]  rem_q;
  logic [DC_W-1:0]   div_cnt_q;

  logic [SUM_W-1:0]  sum_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [OA_W-1:0]   out_addr_nxt;
  logic [SUM_W:0]    rem_sh;
  logic              q_bit;
  logic [SUM_W-1:0]  rem_nxt;
  logic              px_last, py_last, bx_last, by_last;

  always_comb begin
    sum_nxt      = sum_q + SUM_W'(rd_data);
    rd_addr_nxt  = ADDR_W'(BASE_ADDR)
                 + (ADDR_W'(by_q) * ADDR_W'(BLK_H) + ADDR_W'(py_q)) * ADDR_W'(SRC_W)
                 + ADDR_W'(bx_q) * ADDR_W'(BLK_W) + ADDR_W'(px_q);
    out_addr_nxt = OA_W'(by_q) * OA_W'(OUT_W) + OA_W'(bx_q);
    // One restoring step: bring in the next dividend bit, subtract N if it fits.
    rem_sh       = {rem_q, dvd_q[SUM_W-1]};
    q_bit        = (rem_sh >= (SUM_W+1)'(N));
    rem_nxt      = q_bit ? SUM_W'(rem_sh - (SUM_W+1)'(N)) : rem_sh[SUM_W-1:0];
    px_last      = (px_q == PX_W'(BLK_W - 1));
    py_last      = (py_q == PY_W'(BLK_H - 1));
    bx_last      = (bx_q == BX_W'(OUT_W - 1));
    by_last      = (by_q == BY_W'(OUT_H - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      px_q      <= '0;
      py_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      sum_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_req <= 1'b0;
      out_we <= 1'b0;
      done   <= 1'b0;
      case (state_q)
        StIdle: begin
          // busy lingers one cycle after done; a start seen then is still ignored.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            px_q    <= '0;
            py_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            sum_q   <= '0;
            busy    <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          rd_req  <= 1'b1;
          rd_addr <= rd_addr_nxt;
          state_q <= StWait;
        end
        StWait: begin
          if (rd_valid) begin
            sum_q <= sum_nxt;
            if (px_last) begin
              px_q <= '0;
              if (py_last) begin
                py_q      <= '0;
                dvd_q     <= sum_nxt + RND;
                rem_q     <= '0;
                div_cnt_q <= '0;
                state_q   <= StDiv;
              end else begin
                py_q    <= py_q + PY_W'(1);
                state_q <= StReq;
              end
            end else begin
              px_q    <= px_q + PX_W'(1);
              state_q <= StReq;
            end
          end
        end
        StDiv: begin
          dvd_q     <= {dvd_q[SUM_W-2:0], q_bit};
          rem_q     <= rem_nxt;
          div_cnt_q <= div_cnt_q + DC_W'(1);
          if (div_cnt_q == DC_W'(SUM_W - 1)) state_q <= StWrite;
        end
        StWrite: begin
          out_we   <= 1'b1;
          out_addr <= out_addr_nxt;
          out_data <= dvd_q[PIX_W-1:0];
          sum_q    <= '0;
          if (bx_last) begin
            bx_q <= '0;
            if (by_last) begin
              state_q <= StDone;
            end else begin
              by_q    <= by_q + BY_W'(1);
              state_q <= StReq;
            end
          end else begin
            bx_q    <= bx_q + BX_W'(1);
            state_q <= StReq;
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/image_resize_avg_stream.md
IMAGE_RESIZE_AVG_STREAM -- requirements
Module: image_resize_avg_stream

Interface
REQ-001 SHALL have parameter SRC_W, default 640, meaning source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 480, meaning source image height in pixels.
REQ-003 SHALL have parameter BLK_W, default 20, meaning averaging block width; SRC_W SHALL be a multiple of BLK_W.
REQ-004 SHALL have parameter BLK_H, default 15, meaning averaging block height; SRC_H SHALL be a multiple of BLK_H.
REQ-005 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-006 SHALL have parameter ADDR_W, default 23, meaning read address width.
REQ-007 SHALL have parameter BASE_ADDR, default 0, meaning the frame start address.
REQ-008 SHALL derive OUT_W=SRC_W/BLK_W, OUT_H=SRC_H/BLK_H, N=BLK_W*BLK_H, SUM_W=PIX_W+clog2(N)+1, OA_W=clog2(OUT_W*OUT_H).
REQ-009 clk  in  1  sole clock; all logic on its rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 start  in  1  one-cycle request to process one frame.
REQ-012 rd_req  out  1  one-cycle read request pulse.
REQ-013 rd_addr  out  ADDR_W  read address; valid when rd_req=1.
REQ-014 rd_valid  in  1  read data valid, any latency >=1 cycle after rd_req.
REQ-015 rd_data  in  PIX_W  pixel data, sampled when rd_valid=1.
REQ-016 out_we  out  1  one-cycle result write strobe.
REQ-017 out_addr  out  OA_W  result index = by*OUT_W+bx.
REQ-018 out_data  out  PIX_W  block average.
REQ-019 busy  out  1  high from accepted start until done.
REQ-020 done  out  1  one-cycle pulse after the last result write.

Function
REQ-021 States SHALL be IDLE, REQ, WAIT, DIV, WRITE, DONE.
REQ-022 IDLE: start=1 -> REQ; clear x/y/bx/by counters and sum; busy=1 next cycle.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 REQ: rd_req=1 for exactly one cycle, rd_addr=BASE_ADDR+(by*BLK_H+py)*SRC_W+bx*BLK_W+px -> WAIT.
REQ-025 Only one read SHALL be outstanding; rd_valid outside WAIT SHALL be ignored.
REQ-026 WAIT: on rd_valid, sum+=rd_data (SUM_W bits, no overflow); if not last pixel of block advance px (wrap at BLK_W-1, then py++) -> REQ; if last -> DIV.
REQ-027 Pixel order within a block SHALL be row-major; block order SHALL be row-major over the OUT_W x OUT_H grid.
REQ-028 DIV: restoring sequential divide of dividend by constant N, exactly SUM_W cycles, then -> WRITE.
REQ-029 WRITE: out_we=1 one cycle with out_addr and quotient (low PIX_W bits, always <2^PIX_W); clear sum; if bx=OUT_W-1 and by=OUT_H-1 -> DONE, else advance bx (wrap to 0, by++) -> REQ.
REQ-030 DONE: done=1 one cycle, busy=0 next cycle -> IDLE.
REQ-031 Total results per frame SHALL be exactly OUT_W*OUT_H, each address written once.

Reset
REQ-032 rst=1 SHALL force IDLE; rd_req, out_we, done, busy = 0; rd_addr, out_addr, out_data, counters, sum = 0.
REQ-033 rst asserted mid-frame SHALL abort immediately with no further rd_req/out_we/done; rd_valid arriving after reset SHALL be ignored.
REQ-034 start coincident with rst SHALL be ignored.

Configuration
REQ-035 Macro IMAGE_RESIZE_ROUND_EN defined: dividend = sum + N/2 (round-half-up).
REQ-036 Macro IMAGE_RESIZE_ROUND_EN undefined: dividend = sum (truncation); all timing identical in both builds.

Verification
REQ-037 Params SRC 8x4, BLK 4x2, rd_valid 1 cycle after rd_req, all pixels 100 -> 4 writes, addr 0,1,2,3 each data 100, then done pulse.
REQ-038 Same params, block 0 pixels 0,0,0,0,1,1,1,1 -> out_addr 0 data 0 without ROUND_EN, data 1 with ROUND_EN.
REQ-039 Same params, rd_valid latency randomised 1-5 cycles, pixel value = address -> rd_addr sequence 0,1,2,3,8,9,10,11 for block 0; averages match model.
REQ-040 Default params, all pixels 255 -> 1024 writes of 255, no overflow, busy high throughout, done once.
REQ-041 rst asserted after 3rd out_we, then start -> no writes between, new frame restarts at out_addr 0, rd_addr BASE_ADDR.
REQ-042 start pulsed while busy -> ignored, exactly one done per accepted start.
